// File: rtl/qreg_pkg.sv
// rtl/qreg_pkg.sv - shared Q-register select encodings and field positions
package qreg_pkg;

  typedef enum logic [1:0] {
    QS_HOLD = 2'b00,
    QS_SHL  = 2'b01,
    QS_SHR  = 2'b10,
    QS_LOAD = 2'b11
  } qsel_t;

  localparam int QSEL_LSB = 0;
  localparam int QSEL_MSB = 1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/qreg_stepcnt.sv
// rtl/qreg_stepcnt.sv - saturating same-direction shift step counter
module qreg_stepcnt
  import qreg_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd,
  input  logic [1:0]       qs,
  input  logic             step_clr,
  output logic [CNT_W-1:0] step_cnt,
  output logic             step_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  qsel_t sel;
  logic  dir;
  logic  last_dir;
  logic  cont;

  assign sel  = qsel_t'(qs);
  assign dir  = (sel == QS_SHR) ? DIR_RIGHT : DIR_LEFT;
  // A clear on the same edge as a shift restarts the run, so it never continues
  assign cont = !step_clr && (dir == last_dir) && (step_cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
      last_dir <= DIR_LEFT;
    end else if (upd) begin
      if (sel == QS_LOAD) begin
        step_cnt <= '0;
      end else if (cont) begin
        if (step_cnt != CNT_MAX)
          step_cnt <= step_cnt + 1'b1;
      end else begin
        step_cnt <= CNT_W'(1);
        last_dir <= dir;
      end
    end else if (step_clr) begin
      step_cnt <= '0;
    end
  end

  assign step_done = (step_cnt == CNT_MAX);

endmodule

// File: rtl/qreg_unit.sv
// rtl/qreg_unit.sv - Q register, shift/load select decode and source-bus drive
// Optional registered even parity of q via QREG_PARITY_EN.
module qreg_unit
  import qreg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IR_W  = 49,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             state_alu,
  input  logic             state_write,
  input  logic             state_mmu,
  input  logic             state_fetch,
  input  logic [IR_W-1:0]  ir,
  input  logic             iralu,
  input  logic             srcq,
  input  logic [WIDTH-1:0] alu,
  input  logic             step_clr,
  output logic             qs0,
  output logic             qs1,
  output logic             qdrive,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bus,
  output logic [CNT_W-1:0] step_cnt,
  output logic             step_done
`ifdef QREG_PARITY_EN
  ,
  output logic             q_parity
`endif
);

  qsel_t            qs;
  logic             upd;
  logic [WIDTH-1:0] q_next;
  logic             unused_ir;

  assign unused_ir = ^ir[IR_W-1:QSEL_MSB+1];

  assign qs0 = ir[QSEL_LSB] & iralu;
  assign qs1 = ir[QSEL_MSB] & iralu;
  assign qs  = qsel_t'({qs1, qs0});
  assign upd = state_write & iralu & (qs != QS_HOLD);

  // Left shift feeds the inverted ALU sign in as the next quotient bit
  always_comb begin
    q_next = q;
    case (qs)
      QS_SHL:  q_next = {q[WIDTH-2:0], ~alu[WIDTH-1]};
      QS_SHR:  q_next = {alu[0], q[WIDTH-1:1]};
      QS_LOAD: q_next = alu;
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (upd)
      q <= q_next;
  end

`ifdef QREG_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q_parity <= 1'b0;
    else if (upd)
      q_parity <= ^q_next;
  end
`endif

  assign qdrive = srcq & (state_alu | state_write | state_mmu | state_fetch);
  assign q_bus  = qdrive ? q : '0;

  qreg_stepcnt #(.WIDTH(WIDTH)) u_stepcnt (
    .clk       (clk),
    .reset     (reset),
    .upd       (upd),
    .qs        (qs),
    .step_clr  (step_clr),
    .step_cnt  (step_cnt),
    .step_done (step_done)
  );

endmodule

// File: tb/tb_qreg_unit.sv
// tb/tb_qreg_unit.sv - directed vector bench for qreg_unit (WIDTH=32)
module tb_qreg_unit;

  localparam int WIDTH = 32;
  localparam int IR_W  = 49;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             state_alu = 1'b0;
  logic             state_write = 1'b0;
  logic             state_mmu = 1'b0;
  logic             state_fetch = 1'b0;
  logic [IR_W-1:0]  ir = '0;
  logic             iralu = 1'b0;
  logic             srcq = 1'b0;
  logic [WIDTH-1:0] alu = '0;
  logic             step_clr = 1'b0;
  logic             qs0, qs1, qdrive, step_done;
  logic [WIDTH-1:0] q, q_bus;
  logic [CNT_W-1:0] step_cnt;
`ifdef QREG_PARITY_EN
  logic             q_parity;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qreg_unit #(.WIDTH(WIDTH), .IR_W(IR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .state_alu   (state_alu),
    .state_write (state_write),
    .state_mmu   (state_mmu),
    .state_fetch (state_fetch),
    .ir          (ir),
    .iralu       (iralu),
    .srcq        (srcq),
    .alu         (alu),
    .step_clr    (step_clr),
    .qs0         (qs0),
    .qs1         (qs1),
    .qdrive      (qdrive),
    .q           (q),
    .q_bus       (q_bus),
    .step_cnt    (step_cnt),
    .step_done   (step_done)
`ifdef QREG_PARITY_EN
    ,
    .q_parity    (q_parity)
`endif
  );

  typedef struct {
    logic [1:0]  qsel;
    logic        iralu;
    logic        sw;
    logic        sm;
    logic        srcq;
    logic        clr;
    logic [31:0] alu;
    logic [1:0]  exp_qs;
    logic        exp_qdrive;
    logic [31:0] exp_q;
    int          exp_cnt;
    logic        exp_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_shift(input logic [1:0] sel, input logic [31:0] a);
    @(negedge clk);
    ir = '0;
    ir[1:0] = sel;
    iralu = 1'b1;
    state_write = 1'b1;
    step_clr = 1'b0;
    alu = a;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[14];
  logic [31:0] prev_q;

  initial begin
    // qsel iralu sw sm srcq clr alu exp_qs qdrv exp_q cnt done
    vecs[0]  = '{2'b11, 1, 1, 0, 0, 0, 32'hDEADBEEF, 2'b11, 0, 32'hDEADBEEF, 0, 0};
    vecs[1]  = '{2'b11, 1, 1, 0, 0, 0, 32'h00000001, 2'b11, 0, 32'h00000001, 0, 0};
    vecs[2]  = '{2'b01, 1, 1, 0, 0, 0, 32'h00000000, 2'b01, 0, 32'h00000003, 1, 0};
    vecs[3]  = '{2'b01, 1, 1, 0, 0, 0, 32'h80000000, 2'b01, 0, 32'h00000006, 2, 0};
    vecs[4]  = '{2'b11, 1, 1, 0, 0, 0, 32'h80000000, 2'b11, 0, 32'h80000000, 0, 0};
    vecs[5]  = '{2'b10, 1, 1, 0, 1, 0, 32'h00000001, 2'b10, 1, 32'hC0000000, 1, 0};
    vecs[6]  = '{2'b10, 1, 1, 0, 0, 0, 32'h00000000, 2'b10, 0, 32'h60000000, 2, 0};
    vecs[7]  = '{2'b11, 1, 0, 1, 1, 0, 32'h00000005, 2'b11, 1, 32'h60000000, 2, 0};
    vecs[8]  = '{2'b11, 0, 1, 0, 0, 0, 32'h00000005, 2'b00, 0, 32'h60000000, 2, 0};
    vecs[9]  = '{2'b01, 1, 1, 0, 0, 0, 32'h00000000, 2'b01, 0, 32'hC0000001, 1, 0};
    vecs[10] = '{2'b00, 0, 0, 0, 1, 1, 32'h00000000, 2'b00, 0, 32'hC0000001, 0, 0};
    vecs[11] = '{2'b01, 1, 1, 0, 0, 0, 32'h00000000, 2'b01, 0, 32'h80000003, 1, 0};
    vecs[12] = '{2'b01, 1, 1, 0, 0, 1, 32'h00000000, 2'b01, 0, 32'h00000007, 1, 0};
    vecs[13] = '{2'b11, 1, 1, 0, 0, 1, 32'h00000003, 2'b11, 0, 32'h00000003, 0, 0};

    #2 reset = 1'b1;
    #1;
    check("reset_q", q, 32'h0);
    check("reset_cnt", 32'(step_cnt), 32'd0);
    check("reset_done", 32'(step_done), 32'd0);
    check("reset_qbus", q_bus, 32'h0);
`ifdef QREG_PARITY_EN
    check("reset_parity", 32'(q_parity), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    prev_q = 32'h0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ir = '0;
      ir[1:0] = vecs[i].qsel;
      ir[IR_W-1] = 1'b1;
      iralu = vecs[i].iralu;
      state_write = vecs[i].sw;
      state_mmu = vecs[i].sm;
      srcq = vecs[i].srcq;
      step_clr = vecs[i].clr;
      alu = vecs[i].alu;
      #1;
      check($sformatf("v%0d_qs", i), {30'd0, qs1, qs0}, {30'd0, vecs[i].exp_qs});
      check($sformatf("v%0d_qdrive", i), 32'(qdrive), 32'(vecs[i].exp_qdrive));
      check($sformatf("v%0d_qbus", i), q_bus, vecs[i].exp_qdrive ? prev_q : 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("v%0d_cnt", i), 32'(step_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_done", i), 32'(step_done), 32'(vecs[i].exp_done));
      prev_q = vecs[i].exp_q;
    end

    // Saturation: step count reaches 32 and holds through extra shifts
    srcq = 1'b0;
    state_mmu = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      drive_shift(2'b01, 32'h0);
      check($sformatf("sat%0d_cnt", i), 32'(step_cnt), (i >= 32) ? 32'd32 : 32'(i));
      check($sformatf("sat%0d_done", i), 32'(step_done), (i >= 32) ? 32'd1 : 32'd0);
    end
    check("sat_q", q, 32'hFFFFFFFF);
    drive_shift(2'b10, 32'h0);
    check("sat_rev_cnt", 32'(step_cnt), 32'd1);
    check("sat_rev_done", 32'(step_done), 32'd0);
    check("sat_rev_q", q, 32'h7FFFFFFF);

    // Asynchronous reset between edges after five shifts
    for (int i = 0; i < 5; i++) drive_shift(2'b01, 32'h0);
    check("pre_rst_cnt", 32'(step_cnt), 32'd5);
    @(negedge clk);
    state_write = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_q", q, 32'h0);
    check("async_rst_cnt", 32'(step_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_shift(2'b01, 32'h0);
    check("post_rst_cnt", 32'(step_cnt), 32'd1);
    check("post_rst_q", q, 32'h00000001);

`ifdef QREG_PARITY_EN
    drive_shift(2'b11, 32'h00000007);
    check("parity_7", 32'(q_parity), 32'd1);
    drive_shift(2'b11, 32'h00000003);
    check("parity_3", 32'(q_parity), 32'd0);
`endif

    @(negedge clk);
    state_write = 1'b0;
    iralu = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/qreg_unit.md
Name: qreg_unit

Overview:
Parametrised successor to the Q-register control path: holds the Q register itself and decodes the shift/load select.
- Performs left/right shift (multiply/divide steps) and load from the ALU result, one update per microinstruction in the write state.
- Tracks consecutive shift steps in a saturating counter so sequencing logic can detect completion of an N-step multiply/divide.
- Drives Q onto the source bus when selected.

Parameters:
- WIDTH, 32, Q register and ALU data width (>=4)
- IR_W, 49, microinstruction width
- CNT_W, $clog2(WIDTH+1), step counter width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- state_alu  in  1  machine in ALU state
- state_write  in  1  machine in write state; Q update strobe
- state_mmu  in  1  machine in MMU state
- state_fetch  in  1  machine in fetch state
- ir  in  IR_W  current microinstruction; ir[1:0] = Q select
- iralu  in  1  microinstruction is ALU class
- srcq  in  1  Q selected as M-source
- alu  in  WIDTH  ALU result
- step_clr  in  1  synchronous clear of step counter
- qs0  out  1  ir[0] & iralu (combinational)
- qs1  out  1  ir[1] & iralu (combinational)
- qdrive  out  1  Q drives source bus (combinational)
- q  out  WIDTH  Q register contents
- q_bus  out  WIDTH  q when qdrive, else 0
- step_cnt  out  CNT_W  consecutive same-direction shift count
- step_done  out  1  step_cnt == WIDTH
- q_parity  out  1  present only with QREG_PARITY_EN

Behaviour:
- Clocking: one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - q = 0, step_cnt = 0, last_dir = 0, step_done = 0, q_parity = 0.
  - qs0, qs1, qdrive and q_bus follow their inputs combinationally; q_bus = 0 because q = 0.
- Select decode: qs = {qs1,qs0}. 00 hold; 01 shift left; 10 shift right; 11 load.
- Update enable: upd = state_write & iralu & (qs != 00). Q changes only on a clk rising edge with upd = 1; otherwise it holds.
- Shift left: q <= {q[WIDTH-2:0], ~alu[WIDTH-1]}. The inverted ALU sign is the quotient bit.
- Shift right: q <= {alu[0], q[WIDTH-1:1]}. The ALU LSB enters the MSB.
- Load: q <= alu.
- Latency: the new q is visible the cycle after the write-state edge. An M-source read of Q in the same cycle as an update returns the old value.
- qdrive = srcq & (state_alu | state_write | state_mmu | state_fetch). qdrive is combinational and unaffected by reset.
- Step counter, on each upd edge:
  - shift with the same direction as last_dir and step_cnt != 0: step_cnt <= min(step_cnt+1, WIDTH).
  - shift with a new direction, or step_cnt == 0: step_cnt <= 1; last_dir <= direction (0 = left, 1 = right).
  - load: step_cnt <= 0.
  - no upd: step_cnt holds.
- Saturation: step_cnt stays at WIDTH with no wrap. step_done is registered-equivalent: a pure decode of step_cnt, held while saturated.
- step_clr:
  - step_clr with no upd: step_cnt <= 0.
  - step_clr with a shift on the same edge: step_cnt <= 1 and last_dir updates (the clear applies first, then the shift counts).
  - step_clr with a load: step_cnt <= 0.
  - step_clr never affects q.
- Reset mid-sequence: all state returns immediately to reset values. The first shift after reset counts as 1.
- Inactive non-ALU microinstructions (iralu = 0) force qs = 00 regardless of ir.

Optional Feature:
- QREG_PARITY_EN defined:
  - adds a registered q_parity output = even parity (^) of the value being written into q, updated on the same edge as q.
  - reset value 0, consistent with q = 0.
- QREG_PARITY_EN undefined: the q_parity port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package qreg_pkg:
  - qsel_t enum: QS_HOLD = 2'b00, QS_SHL = 2'b01, QS_SHR = 2'b10, QS_LOAD = 2'b11.
  - constants QSEL_LSB = 0 and QSEL_MSB = 1 (ir field position).
  - direction constants DIR_LEFT = 0, DIR_RIGHT = 1.
- Sub-module qreg_stepcnt: the saturating counter plus direction tracker. Inputs upd, qs, step_clr; outputs step_cnt, step_done. Q datapath and decode stay in the top level.

Test Plan:
- Reset then load: reset pulse, then iralu=1, ir[1:0]=11, alu=32'hDEADBEEF, state_write=1 for one edge.
  -> q = 32'hDEADBEEF next cycle; step_cnt = 0.
- Left shift: q=32'h00000001, alu[31]=0, qs=01, one write edge.
  -> q = 32'h00000003; step_cnt = 1.
- Right shift: q=32'h80000000, alu[0]=1, qs=10.
  -> q = 32'hC0000000.
- Saturation: 34 consecutive left shifts with write strobes.
  -> step_cnt reaches 32 on the 32nd edge; step_done = 1 from that cycle and holds through shifts 33-34.
  -> then one right shift gives step_cnt = 1 and step_done = 0.
- Gating: qs=11, alu=5, state_write=0 (or iralu=0).
  -> q unchanged; qs0 = qs1 = 0 when iralu = 0.
  -> srcq=1 with state_mmu=1 gives qdrive = 1 and q_bus = q; srcq=1 with all states low gives q_bus = 0.
- Async reset mid-sequence: assert reset between edges after 5 shifts.
  -> q = 0 and step_cnt = 0 immediately, without a clock edge.
  -> with QREG_PARITY_EN, load 32'h00000007 -> q_parity = 1; load 32'h00000003 -> q_parity = 0.
